// File: rtl/floo_axis_noc_bridge_buffered.sv
// Bridge between FlooNoC flit channels and a single AXI-Stream link.
// TX packs all valid channel flits into one registered beat with a per-slot
// valid mask; RX unpacks beats into one FIFO per channel so a stalled
// channel only blocks the link once its own FIFO is full.
`timescale 1ns/1ps

module floo_axis_noc_bridge_buffered #(
    parameter int unsigned NumChannels = 2,
    parameter int unsigned FlitWidth   = 64,
    parameter int unsigned FifoDepth   = 4,
    parameter int unsigned CntWidth    = 16,
    parameter int unsigned AxisWidth   = NumChannels * (FlitWidth + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumChannels-1:0]           flit_in_valid_i,
    output logic [NumChannels-1:0]           flit_in_ready_o,
    input  logic [NumChannels*FlitWidth-1:0] flit_in_data_i,
    output logic [NumChannels-1:0]           flit_out_valid_o,
    input  logic [NumChannels-1:0]           flit_out_ready_i,
    output logic [NumChannels*FlitWidth-1:0] flit_out_data_o,
    output logic                             axis_out_tvalid_o,
    input  logic                             axis_out_tready_i,
    output logic [AxisWidth-1:0]             axis_out_tdata_o,
    input  logic                             axis_in_tvalid_i,
    output logic                             axis_in_tready_o,
    input  logic [AxisWidth-1:0]             axis_in_tdata_i,
    output logic [CntWidth-1:0]              tx_beats_o,
    output logic [CntWidth-1:0]              rx_beats_o
);

    localparam int unsigned SlotW = FlitWidth + 1;
    localparam int unsigned PtrW  = $clog2(FifoDepth);

    logic                   out_valid_q;
    logic [AxisWidth-1:0]   out_data_q;
    logic [AxisWidth-1:0]   tx_beat;
    logic                   tx_free;
    logic                   tx_hs;
    logic                   rx_hs;
    logic [NumChannels-1:0] fifo_full;
    logic [CntWidth-1:0]    tx_beats_q;
    logic [CntWidth-1:0]    rx_beats_q;

    // The output register may reload whenever it is empty or being drained;
    // flit ready therefore depends on tready but never on flit valid.
    assign tx_free         = !out_valid_q || axis_out_tready_i;
    assign flit_in_ready_o = {NumChannels{tx_free}};
    assign tx_hs           = out_valid_q && axis_out_tready_i;

    // Pack valid flits with their mask bit; idle slots are forced to zero.
    always_comb begin
        tx_beat = '0;
        for (int i = 0; i < NumChannels; i++) begin
            if (flit_in_valid_i[i]) begin
                tx_beat[i*SlotW +: SlotW] = {1'b1, flit_in_data_i[i*FlitWidth +: FlitWidth]};
            end
        end
    end

    // TX beat register: load when free, otherwise hold the stalled beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (tx_free) begin
            out_valid_q <= |flit_in_valid_i;
            out_data_q  <= tx_beat;
        end
    end

    assign axis_out_tvalid_o = out_valid_q;
    assign axis_out_tdata_o  = out_data_q;

    // The link is only backpressured when some channel FIFO is full.
    assign axis_in_tready_o = ~|fifo_full;
    assign rx_hs            = axis_in_tvalid_i && axis_in_tready_o;

    for (genvar i = 0; i < NumChannels; i++) begin : g_ch
        logic [FlitWidth-1:0] mem_q [FifoDepth];
        logic [PtrW:0]        wr_ptr_q;
        logic [PtrW:0]        rd_ptr_q;
        logic                 empty;
        logic                 push;
        logic                 pop;

        // Extra pointer MSB distinguishes full from empty on equal indices.
        assign empty        = (wr_ptr_q == rd_ptr_q);
        assign fifo_full[i] = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                              (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
        assign push         = rx_hs && axis_in_tdata_i[i*SlotW + FlitWidth];
        assign pop          = !empty && flit_out_ready_i[i];

        assign flit_out_valid_o[i]                       = !empty;
        assign flit_out_data_o[i*FlitWidth +: FlitWidth] = mem_q[rd_ptr_q[PtrW-1:0]];

        // Pointer update; push and pop are independent so both may occur together.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + (PtrW+1)'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + (PtrW+1)'(1);
            end
        end

        // Storage carries no reset; validity is tracked by the pointers alone.
        always_ff @(posedge clk_i) begin
            if (push) mem_q[wr_ptr_q[PtrW-1:0]] <= axis_in_tdata_i[i*SlotW +: FlitWidth];
        end
    end

    // Beat counters on link handshakes, wrapping naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_beats_q <= '0;
            rx_beats_q <= '0;
        end else begin
            if (tx_hs) tx_beats_q <= tx_beats_q + CntWidth'(1);
            if (rx_hs) rx_beats_q <= rx_beats_q + CntWidth'(1);
        end
    end

    assign tx_beats_o = tx_beats_q;
    assign rx_beats_o = rx_beats_q;

endmodule

// File: tb/tb_floo_axis_noc_bridge_buffered.sv
// Directed bench for floo_axis_noc_bridge_buffered with two 8-bit channels,
// 4-deep RX FIFOs and 4-bit beat counters.
`timescale 1ns/1ps

module tb_floo_axis_noc_bridge_buffered;

    localparam int NCH = 2;
    localparam int FW  = 8;
    localparam int FD  = 4;
    localparam int CW  = 4;
    localparam int AW  = NCH * (FW + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    flit_in_valid;
    logic [NCH-1:0]    flit_in_ready;
    logic [NCH*FW-1:0] flit_in_data;
    logic [NCH-1:0]    flit_out_valid;
    logic [NCH-1:0]    flit_out_ready;
    logic [NCH*FW-1:0] flit_out_data;
    logic              out_tvalid;
    logic              out_tready;
    logic [AW-1:0]     out_tdata;
    logic              in_tvalid;
    logic              in_tready;
    logic [AW-1:0]     in_tdata;
    logic [CW-1:0]     tx_beats;
    logic [CW-1:0]     rx_beats;

    int n_tests = 0;
    int n_fail  = 0;

    floo_axis_noc_bridge_buffered #(
        .NumChannels(NCH), .FlitWidth(FW), .FifoDepth(FD), .CntWidth(CW)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .flit_in_valid_i  (flit_in_valid),
        .flit_in_ready_o  (flit_in_ready),
        .flit_in_data_i   (flit_in_data),
        .flit_out_valid_o (flit_out_valid),
        .flit_out_ready_i (flit_out_ready),
        .flit_out_data_o  (flit_out_data),
        .axis_out_tvalid_o(out_tvalid),
        .axis_out_tready_i(out_tready),
        .axis_out_tdata_o (out_tdata),
        .axis_in_tvalid_i (in_tvalid),
        .axis_in_tready_o (in_tready),
        .axis_in_tdata_i  (in_tdata),
        .tx_beats_o       (tx_beats),
        .rx_beats_o       (rx_beats)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] mk_beat(input logic m1, input logic [7:0] d1,
                                               input logic m0, input logic [7:0] d0);
        return {m1, d1, m0, d0};
    endfunction

    initial begin
        // Reset held with random activity on every input
        rst_n          = 1'b0;
        flit_in_valid  = NCH'($urandom);
        flit_in_data   = (NCH*FW)'($urandom);
        flit_out_ready = NCH'($urandom);
        out_tready     = 1'($urandom);
        in_tvalid      = 1'b1;
        in_tdata       = AW'($urandom);
        tick(); tick(); tick();
        chk("rst_tvalid", 32'(out_tvalid), 32'd0);
        chk("rst_tdata", 32'(out_tdata), 32'd0);
        chk("rst_flit_out_valid", 32'(flit_out_valid), 32'd0);
        chk("rst_tx_beats", 32'(tx_beats), 32'd0);
        chk("rst_rx_beats", 32'(rx_beats), 32'd0);

        flit_in_valid  = '0;
        flit_in_data   = '0;
        flit_out_ready = '0;
        out_tready     = 1'b0;
        in_tvalid      = 1'b0;
        in_tdata       = '0;
        rst_n          = 1'b1;
        #1;
        chk("post_rst_in_tready", 32'(in_tready), 32'd1);
        chk("post_rst_flit_in_ready", 32'(flit_in_ready), 32'h3);

        // TX single flit on ch1
        out_tready    = 1'b1;
        flit_in_valid = 2'b10;
        flit_in_data  = 16'hA500;
        tick();
        flit_in_valid = 2'b00;
        chk("tx1_tvalid", 32'(out_tvalid), 32'd1);
        chk("tx1_tdata", 32'(out_tdata), 32'h34A00);
        chk("tx1_beats_before", 32'(tx_beats), 32'd0);
        tick();
        chk("tx1_beats_after", 32'(tx_beats), 32'd1);
        chk("tx1_tvalid_idle", 32'(out_tvalid), 32'd0);

        // TX stall: beat 0x122 pending, 0x11 waiting on ch0
        out_tready    = 1'b0;
        flit_in_valid = 2'b01;
        flit_in_data  = 16'h0022;
        tick();
        flit_in_data  = 16'h0011;
        for (int c = 0; c < 3; c++) begin
            chk("stall_flit_ready", 32'(flit_in_ready), 32'd0);
            chk("stall_tdata", 32'(out_tdata), 32'h122);
            chk("stall_tvalid", 32'(out_tvalid), 32'd1);
            if (c < 2) tick();
        end
        out_tready = 1'b1;
        #1;
        chk("unstall_flit_ready", 32'(flit_in_ready), 32'h3);
        tick();
        flit_in_valid = 2'b00;
        chk("unstall_next_tdata", 32'(out_tdata), 32'h111);
        chk("unstall_tx_beats", 32'(tx_beats), 32'd2);
        tick();
        chk("unstall_tx_beats2", 32'(tx_beats), 32'd3);
        chk("unstall_tvalid_idle", 32'(out_tvalid), 32'd0);

        // RX decoupling: ch0 blocked, ch1 drains
        flit_out_ready = 2'b10;
        for (int k = 1; k <= 4; k++) begin
            in_tvalid = 1'b1;
            in_tdata  = mk_beat(1'b1, 8'(k), 1'b1, 8'(k));
            tick();
            chk("rx_ch1_data", 32'(flit_out_data[15:8]), 32'(k));
            chk("rx_ch1_valid", 32'(flit_out_valid[1]), 32'd1);
        end
        chk("rx_full_tready", 32'(in_tready), 32'd0);
        chk("rx_ch0_head", 32'(flit_out_data[7:0]), 32'd1);
        in_tdata = mk_beat(1'b1, 8'd5, 1'b1, 8'd5);
        tick();
        chk("rx_beat5_stalled", 32'(in_tready), 32'd0);
        chk("rx_beats_4", 32'(rx_beats), 32'd4);
        chk("rx_ch1_drained", 32'(flit_out_valid[1]), 32'd0);
        flit_out_ready = 2'b11;
        #1;
        chk("rx_pop_full_same_cycle", 32'(in_tready), 32'd0);
        tick();
        flit_out_ready = 2'b10;
        chk("rx_pop_full_next_cycle", 32'(in_tready), 32'd1);
        chk("rx_ch0_head2", 32'(flit_out_data[7:0]), 32'd2);
        tick();
        in_tvalid = 1'b0;
        chk("rx_beats_5", 32'(rx_beats), 32'd5);
        chk("rx_ch1_data5", 32'(flit_out_data[15:8]), 32'd5);
        tick();
        chk("rx_ch0_full_again", 32'(in_tready), 32'd0);

        // Same-cycle push/pop on ch0 at usage 2
        flit_out_ready = 2'b01;
        tick();
        chk("rx_ch0_head3", 32'(flit_out_data[7:0]), 32'd3);
        tick();
        chk("rx_ch0_head4", 32'(flit_out_data[7:0]), 32'd4);
        chk("rx_tready_usage2", 32'(in_tready), 32'd1);
        in_tvalid = 1'b1;
        in_tdata  = mk_beat(1'b0, 8'h00, 1'b1, 8'h66);
        tick();
        in_tvalid      = 1'b0;
        flit_out_ready = 2'b00;
        chk("pp_head5", 32'(flit_out_data[7:0]), 32'd5);
        chk("pp_rx_beats", 32'(rx_beats), 32'd6);
        chk("pp_ch1_empty", 32'(flit_out_valid[1]), 32'd0);
        flit_out_ready = 2'b01;
        tick();
        chk("pp_head66", 32'(flit_out_data[7:0]), 32'h66);
        chk("pp_valid_last", 32'(flit_out_valid[0]), 32'd1);
        tick();
        chk("pp_empty", 32'(flit_out_valid[0]), 32'd0);
        flit_out_ready = 2'b00;

        // Zero-mask beat: counted, nothing pushed
        in_tvalid = 1'b1;
        in_tdata  = mk_beat(1'b0, 8'hFF, 1'b0, 8'h5A);
        tick();
        in_tvalid = 1'b0;
        chk("zmask_rx_beats", 32'(rx_beats), 32'd7);
        chk("zmask_no_push", 32'(flit_out_valid), 32'd0);

        // 17 back-to-back TX beats from tx_beats=3 -> (3+17) mod 16 = 4
        out_tready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            flit_in_valid = 2'b01;
            flit_in_data  = 16'(k);
            tick();
            chk("b2b_tvalid", 32'(out_tvalid), 32'd1);
        end
        chk("b2b_last_tdata", 32'(out_tdata), 32'h110);
        flit_in_valid = 2'b00;
        tick();
        chk("wrap_tx_beats", 32'(tx_beats), 32'd4);
        chk("wrap_tvalid_idle", 32'(out_tvalid), 32'd0);

        // Reset mid-stream with TX beat pending and flits buffered
        out_tready    = 1'b0;
        flit_in_valid = 2'b11;
        flit_in_data  = 16'h7733;
        in_tvalid     = 1'b1;
        in_tdata      = mk_beat(1'b1, 8'd1, 1'b1, 8'd2);
        tick();
        flit_in_valid = 2'b00;
        tick();
        in_tvalid = 1'b0;
        chk("pre_rst_tvalid", 32'(out_tvalid), 32'd1);
        chk("pre_rst_tdata", 32'(out_tdata), 32'h2EF33);
        chk("pre_rst_flit_out_valid", 32'(flit_out_valid), 32'h3);
        chk("pre_rst_rx_beats", 32'(rx_beats), 32'd9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", 32'(out_tvalid), 32'd0);
        chk("mid_rst_tdata", 32'(out_tdata), 32'd0);
        chk("mid_rst_flit_out_valid", 32'(flit_out_valid), 32'd0);
        chk("mid_rst_tx_beats", 32'(tx_beats), 32'd0);
        chk("mid_rst_rx_beats", 32'(rx_beats), 32'd0);
        chk("mid_rst_in_tready", 32'(in_tready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_mid_rst_flit_out_valid", 32'(flit_out_valid), 32'd0);
        chk("post_mid_rst_tvalid", 32'(out_tvalid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/floo_axis_noc_bridge_buffered.md
Name: floo_axis_noc_bridge_buffered

Overview:
- Parametrised successor of the NoC-to-AXI-Stream bridge. Carries NumChannels independent flit channels over one AXIS link.
- TX path: a registered beat packer. The beat is held stable while stalled.
- RX path: one FIFO per channel, so backpressure on one channel does not stall the others until its FIFO fills.
- Sits between the FlooNoC router ports and the serial link AXIS interface.

Parameters:
- NumChannels, 2, number of flit channels (req, rsp, ...); range 1..8.
- FlitWidth, 64, payload bits per flit, excluding valid/ready.
- FifoDepth, 4, RX FIFO entries per channel; power of two, at least 2.
- CntWidth, 16, width of the beat counters.
- AxisWidth, NumChannels*(FlitWidth+1), derived; do not override.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flit_in_valid_i  in  NumChannels  per-channel flit valid from NoC (TX).
- flit_in_ready_o  out  NumChannels  per-channel ready to NoC.
- flit_in_data_i  in  NumChannels*FlitWidth  channel i at [i*FlitWidth +: FlitWidth].
- flit_out_valid_o  out  NumChannels  per-channel flit valid to NoC (RX).
- flit_out_ready_i  in  NumChannels  per-channel ready from NoC.
- flit_out_data_o  out  NumChannels*FlitWidth  same packing as flit_in_data_i.
- axis_out_tvalid_o  out  1  AXIS TX valid.
- axis_out_tready_i  in  1  AXIS TX ready.
- axis_out_tdata_o  out  AxisWidth  AXIS TX beat.
- axis_in_tvalid_i  in  1  AXIS RX valid.
- axis_in_tready_o  out  1  AXIS RX ready.
- axis_in_tdata_i  in  AxisWidth  AXIS RX beat.
- tx_beats_o  out  CntWidth  count of accepted TX beats.
- rx_beats_o  out  CntWidth  count of accepted RX beats.

Behaviour:
- Beat format: slot i occupies [i*(FlitWidth+1) +: FlitWidth+1]. Data is the low FlitWidth bits; the MSB of the slot is the valid-mask bit. Slots with mask 0 carry all-zero data on TX.
- Reset values: axis_out_tvalid_o=0, axis_out_tdata_o=0, flit_out_valid_o=0, counters=0, all FIFOs empty.
- After reset, axis_in_tready_o=1 and flit_in_ready_o=all ones.
- TX register: out_valid_q plus out_data_q.
  - free = !out_valid_q | axis_out_tready_i.
  - flit_in_ready_o[i] = free for every i. Combinational path from tready is allowed; no path from flit_in_valid_i.
  - When free, the next out_valid_q = |flit_in_valid_i. out_data_q captures every valid channel with its mask bit set, others zeroed.
  - Latency is 1 cycle from flit handshake to tvalid.
  - Full throughput: back-to-back beats when tready is held high.
- TX stall: while tvalid & !tready, tdata and tvalid hold unchanged and no flit is accepted.
- tx_beats_o increments on tvalid&tready and wraps modulo 2^CntWidth.
- RX FIFOs:
  - axis_in_tready_o = no FIFO full. It is independent of tdata, tvalid and flit_out_ready_i.
  - On tvalid&tready, slot i is pushed into FIFO i iff its mask bit is set.
  - A beat with an all-zero mask is consumed, counted, and pushes nothing.
- RX FIFO output:
  - No fall-through; a pushed flit appears on flit_out the cycle after the push.
  - flit_out_valid_o[i] = FIFO i not empty, with its head on flit_out_data_o.
  - Pop on valid&ready.
- Push and pop in the same cycle on a non-full FIFO: both occur, usage unchanged, order preserved.
- Pop from a full FIFO: tready rises the next cycle, not the same cycle.
- Pointers wrap modulo FifoDepth; use a full/empty flag or an extra pointer bit.
- rx_beats_o increments on axis_in handshake and wraps.
- Reset asserted mid-operation: all state clears immediately; in-flight beats and buffered flits are discarded.
- Simultaneous TX and RX activity is fully independent.

Test Plan:
- Reset: hold rst_ni low, drive random inputs -> tvalid=0, flit_out_valid=0, counters 0; after release, axis_in_tready=1 and flit_in_ready=2'b11.
- TX single, NumChannels=2, FlitWidth=8: ch1 valid, data 0xA5, tready=1 -> next cycle tvalid=1, tdata=18'h3_4A00 (ch1 slot 0x1A5, ch0 slot 0); tx_beats=1 after the handshake.
- TX stall: beat pending, tready=0 for 3 cycles while ch0 presents 0x11 -> tdata stable, flit_in_ready=0 on all three cycles; tready=1 -> current beat sent, and 0x11 captured at that edge and presented the following cycle.
- RX decoupling, FifoDepth=4: ch0 ready=0, ch1 ready=1, 5 beats with mask 2'b11 and data 1..5 -> ch1 emits 1,2,3,4; tready=0 after the 4th push; 5th beat stalls until ch0 pops one, then is accepted.
- RX same-cycle push/pop on ch0 at usage 2 -> usage stays 2, output order strictly FIFO; a zero-mask beat increments rx_beats only.
- Counter wrap with CntWidth=4: 17 TX beats -> tx_beats_o=1. Reset asserted mid-stream -> all FIFOs empty, tvalid=0 in the same cycle.
